// File: rtl/fetch_decode_stage.sv
// Pipeline front end: PC register, synchronous imem address generation and
// the F/D register with field split for the decoder and register file.
module fetch_decode_stage #(
   parameter int unsigned      ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_q,
   input  logic              stall,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              fd_valid,
   output logic [ADDR_W-1:0] fd_pc,
   output logic [ADDR_W-1:0] fd_pc_plus1,
   output logic [31:0]       fd_insn,
   output logic [4:0]        fd_opcode,
   output logic [4:0]        fd_raw_aluop,
   output logic [4:0]        fd_rd,
   output logic [4:0]        fd_rs,
   output logic [4:0]        fd_rt,
   output logic [4:0]        fd_shamt,
   output logic [31:0]       fd_imm,
   output logic [26:0]       fd_target
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;

   // imem registers its address, so presenting pc_next keeps imem_q == mem[pc].
   always_comb begin
      pc_next = pc + ADDR_W'(1);
      if (reset)
         pc_next = RESET_PC;
      else if (redirect_en)
         pc_next = redirect_pc;
      else if (stall)
         pc_next = pc;
   end

   assign imem_addr = pc_next;

   always_ff @(posedge clock) begin
      pc <= pc_next;
   end

   // Flush writes an all-zero bubble, which decodes as a harmless r0 write.
   always_ff @(posedge clock) begin
      if (reset || redirect_en) begin
         fd_valid <= 1'b0;
         fd_insn  <= 32'h0;
         fd_pc    <= '0;
      end else if (!stall) begin
         fd_valid <= 1'b1;
         fd_insn  <= imem_q;
         fd_pc    <= pc;
      end
   end

   assign fd_pc_plus1  = fd_pc + ADDR_W'(1);
   assign fd_opcode    = fd_insn[31:27];
   assign fd_raw_aluop = fd_insn[6:2];
   assign fd_rd        = fd_insn[26:22];
   assign fd_rs        = fd_insn[21:17];
   assign fd_rt        = fd_insn[16:12];
   assign fd_shamt     = fd_insn[11:7];
   assign fd_imm       = {{15{fd_insn[16]}}, fd_insn[16:0]};
   assign fd_target    = fd_insn[26:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: a synchronous imem model plus a
// vector table of stall/redirect stimulus with hand-computed PC expectations.
module tb_fetch_decode_stage;

   localparam int ADDR_W = 12;

   logic              clock;
   logic              reset;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_q;
   logic              stall;
   logic              redirect_en;
   logic [ADDR_W-1:0] redirect_pc;
   logic              fd_valid;
   logic [ADDR_W-1:0] fd_pc;
   logic [ADDR_W-1:0] fd_pc_plus1;
   logic [31:0]       fd_insn;
   logic [4:0]        fd_opcode;
   logic [4:0]        fd_raw_aluop;
   logic [4:0]        fd_rd;
   logic [4:0]        fd_rs;
   logic [4:0]        fd_rt;
   logic [4:0]        fd_shamt;
   logic [31:0]       fd_imm;
   logic [26:0]       fd_target;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   fetch_decode_stage #(.ADDR_W(ADDR_W), .RESET_PC('0)) dut (
      .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_q(imem_q),
      .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .fd_valid(fd_valid), .fd_pc(fd_pc), .fd_pc_plus1(fd_pc_plus1),
      .fd_insn(fd_insn), .fd_opcode(fd_opcode), .fd_raw_aluop(fd_raw_aluop),
      .fd_rd(fd_rd), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_shamt(fd_shamt),
      .fd_imm(fd_imm), .fd_target(fd_target)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) imem_q <= mem[imem_addr];

   typedef struct {
      logic              stall;
      logic              redir;
      logic [ADDR_W-1:0] rpc;
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_valid;
      logic [ADDR_W-1:0] exp_pc;
   } vec_t;

   vec_t vecs [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_fd(input string tag, input logic exp_valid, input logic [ADDR_W-1:0] exp_pc);
      logic [31:0] ei;
      logic [ADDR_W-1:0] p1;
      ei = exp_valid ? mem[exp_pc] : 32'h0;
      p1 = exp_pc + 12'd1;
      check({tag, ".valid"},  {31'h0, fd_valid}, {31'h0, exp_valid});
      check({tag, ".pc"},     {20'h0, fd_pc}, {20'h0, exp_pc});
      check({tag, ".pc1"},    {20'h0, fd_pc_plus1}, {20'h0, p1});
      check({tag, ".insn"},   fd_insn, ei);
      check({tag, ".opcode"}, {27'h0, fd_opcode}, {27'h0, ei[31:27]});
      check({tag, ".aluop"},  {27'h0, fd_raw_aluop}, {27'h0, ei[6:2]});
      check({tag, ".rd"},     {27'h0, fd_rd}, {27'h0, ei[26:22]});
      check({tag, ".rs"},     {27'h0, fd_rs}, {27'h0, ei[21:17]});
      check({tag, ".rt"},     {27'h0, fd_rt}, {27'h0, ei[16:12]});
      check({tag, ".shamt"},  {27'h0, fd_shamt}, {27'h0, ei[11:7]});
      check({tag, ".imm"},    fd_imm, {{15{ei[16]}}, ei[16:0]});
      check({tag, ".target"}, {5'h0, fd_target}, {5'h0, ei[26:0]});
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      for (int a = 0; a < (1 << ADDR_W); a++)
         mem[a] = a * 32'h9E3779B1 + 32'h01234567;
      mem[1]    = 32'hA5A3FFFF;
      mem[4095] = 32'h7C0BEEF3;

      //          stall redir rpc    addr   valid pc
      vecs[0]  = '{1'b0, 1'b0, 12'd0,    12'd1,    1'b1, 12'd0};
      vecs[1]  = '{1'b0, 1'b0, 12'd0,    12'd2,    1'b1, 12'd1};
      vecs[2]  = '{1'b0, 1'b0, 12'd0,    12'd3,    1'b1, 12'd2};
      vecs[3]  = '{1'b1, 1'b0, 12'd0,    12'd3,    1'b1, 12'd2};
      vecs[4]  = '{1'b1, 1'b0, 12'd0,    12'd3,    1'b1, 12'd2};
      vecs[5]  = '{1'b0, 1'b0, 12'd0,    12'd4,    1'b1, 12'd3};
      vecs[6]  = '{1'b0, 1'b0, 12'd0,    12'd5,    1'b1, 12'd4};
      vecs[7]  = '{1'b0, 1'b0, 12'd0,    12'd6,    1'b1, 12'd5};
      vecs[8]  = '{1'b0, 1'b1, 12'd100,  12'd100,  1'b0, 12'd0};
      vecs[9]  = '{1'b0, 1'b0, 12'd0,    12'd101,  1'b1, 12'd100};
      vecs[10] = '{1'b0, 1'b0, 12'd0,    12'd102,  1'b1, 12'd101};
      vecs[11] = '{1'b1, 1'b1, 12'd40,   12'd40,   1'b0, 12'd0};
      vecs[12] = '{1'b0, 1'b0, 12'd0,    12'd41,   1'b1, 12'd40};
      vecs[13] = '{1'b0, 1'b1, 12'd4095, 12'd4095, 1'b0, 12'd0};
      vecs[14] = '{1'b0, 1'b0, 12'd0,    12'd0,    1'b1, 12'd4095};
      vecs[15] = '{1'b0, 1'b0, 12'd0,    12'd1,    1'b1, 12'd0};
      vecs[16] = '{1'b0, 1'b1, 12'd2,    12'd2,    1'b0, 12'd0};
      vecs[17] = '{1'b0, 1'b1, 12'd7,    12'd7,    1'b0, 12'd0};
      vecs[18] = '{1'b0, 1'b0, 12'd0,    12'd8,    1'b1, 12'd7};
      vecs[19] = '{1'b1, 1'b0, 12'd0,    12'd8,    1'b1, 12'd7};

      reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
      repeat (3) tick();
      check("reset.addr", {20'h0, imem_addr}, 32'h0);
      check_fd("reset", 1'b0, 12'd0);

      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         stall       = vecs[i].stall;
         redirect_en = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         #1;
         check($sformatf("v%0d.addr", i), {20'h0, imem_addr}, {20'h0, vecs[i].exp_addr});
         tick();
         check_fd($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
      end

      // Reset asserted together with stall and redirect: reset wins.
      stall = 1'b1; redirect_en = 1'b1; redirect_pc = 12'd300; reset = 1'b1;
      #1;
      check("rst_mid.addr", {20'h0, imem_addr}, 32'h0);
      tick();
      check_fd("rst_mid", 1'b0, 12'd0);
      stall = 1'b0; redirect_en = 1'b0; reset = 1'b0;
      #1;
      check("rel.addr", {20'h0, imem_addr}, 32'h1);
      tick();
      check_fd("rel0", 1'b1, 12'd0);
      tick();
      check_fd("rel1", 1'b1, 12'd1);

      // Reset during plain fetch, then stall held across release.
      reset = 1'b1;
      tick();
      check_fd("rst_run", 1'b0, 12'd0);
      reset = 1'b0; stall = 1'b1;
      #1;
      check("rst_stall.addr", {20'h0, imem_addr}, 32'h0);
      tick();
      check_fd("rst_stall", 1'b0, 12'd0);
      stall = 1'b0;
      tick();
      check_fd("rst_go", 1'b1, 12'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
